// File: rtl/multicycle_ctrl.sv
// Main sequencer of the multi-cycle RV32I core.
// Walks FETCH/DECODE/EXEC/MEM/WB and owns the imem/dmem handshakes.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [1:0] aluop,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_cause
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_e;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;

  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_load, is_store, is_opimm, is_op, is_fence;
  logic legal;

  always_comb begin
    is_lui   = (opcode == OPC_LUI);
    is_auipc = (opcode == OPC_AUIPC);
    is_jal   = (opcode == OPC_JAL);
    is_jalr  = (opcode == OPC_JALR);
    is_br    = (opcode == OPC_BR);
    is_load  = (opcode == OPC_LOAD);
    is_store = (opcode == OPC_STORE);
    is_opimm = (opcode == OPC_OPIMM);
    is_op    = (opcode == OPC_OP);
    is_fence = (opcode == OPC_FENCE);
    legal    = is_lui | is_auipc | is_jal | is_jalr
             | is_br | is_load | is_store | is_opimm
             | is_op | is_fence;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    aluop       = 2'b00;
    alu_a_sel   = 2'b00;
    alu_b_sel   = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'b00;
    retire      = 1'b0;
    fault       = 1'b0;
    fault_cause = cause_q;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == TMO) begin
          state_d = S_FAULT;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FAULT;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        cnt_d = '0;
        unique case (1'b1)
          is_op: begin
            aluop   = 2'b10;
            state_d = S_WB;
          end
          is_opimm: begin
            aluop     = 2'b11;
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          is_lui: begin
            alu_a_sel = 2'b10;
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          is_auipc, is_jal: begin
            alu_a_sel = 2'b01;
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          is_jalr: begin
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          is_load, is_store: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          is_br: begin
            aluop   = 2'b01;
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'b01 : 2'b00;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          is_fence: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            state_d = S_FAULT;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        // address selects held from EXEC
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        alu_b_sel = 1'b1;
        if (dmem_ready) begin
          cnt_d = '0;
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TMO) begin
          state_d = S_FAULT;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        cnt_d   = '0;
        state_d = S_FETCH;
        if (is_load) begin
          wb_sel = 2'b01;
        end else if (is_jal || is_jalr) begin
          wb_sel = 2'b10;
        end
        if (is_jal) begin
          pc_sel = 2'b01;
        end else if (is_jalr) begin
          pc_sel    = 2'b10;
          alu_b_sel = 1'b1;
        end
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end
    endcase
    if (!rst_n) begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 2'b00;
      aluop       = 2'b00;
      alu_a_sel   = 2'b00;
      alu_b_sel   = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = 2'b00;
      retire      = 1'b0;
      fault       = 1'b0;
      fault_cause = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule
